spongent_sponge: RTL and testbench
==================================

SPONGENT_SPONGE -- requirements
Module: spongent_sponge

Interface
REQ-001 SHALL have parameter N, default 88, hash length in bits (multiple of RATE).
REQ-002 SHALL have parameter CAP, default 80, capacity in bits; state width B = CAP+RATE, a multiple of 4.
REQ-003 SHALL have parameter RATE, default 8, rate in bits.
REQ-004 SHALL have parameter ROUNDS, default 45, rounds per permutation.
REQ-005 SHALL have parameter LFSR_W, default 6, round-counter LFSR width.
REQ-006 SHALL have parameter LFSR_INIT, default 6'h05, LFSR value at the start of every permutation.
REQ-007 SHALL have parameter LFSR_TAPS, default 6'h30, tap mask for the LFSR feedback.
REQ-008 clk  input  1  clock; all state changes on its rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 msg_data  input  RATE  message word; valid bits MSB-aligned.
REQ-011 msg_valid  input  1  msg_data is valid.
REQ-012 msg_last  input  1  the word is the final word of the message.
REQ-013 msg_last_len  input  $clog2(RATE)+1  number of valid bits (1..RATE) in the final word; ignored unless msg_last=1.
REQ-014 msg_ready  output  1  the block accepts a word this cycle.
REQ-015 hash  output  N  digest; the first squeezed block is in hash[N-1 -: RATE].
REQ-016 hash_valid  output  1  hash holds a complete digest.

Function
REQ-017 A word transfer SHALL occur when msg_valid=1 and msg_ready=1 in the same cycle.
REQ-018 FSM states SHALL be IDLE, PERM, PAD, SQUEEZE and DONE; msg_ready=1 only in IDLE and DONE.
REQ-019 On a transfer, the state SHALL become state[RATE-1:0] ^= padded word, then enter PERM.
REQ-020 A transfer in DONE SHALL first zero the state and the hash register, and SHALL clear hash_valid in the same cycle.
REQ-021 Final-word padding with L = msg_last_len < RATE:
 - bits below the L valid bits zeroed;
 - bit RATE-1-L set to 1;
 - no PAD block follows.
REQ-022 If L = RATE, a pad block SHALL be pending: in PAD the state becomes state[RATE-1:0] ^= 1<<(RATE-1) for one cycle, then PERM.
REQ-023 PERM SHALL last exactly ROUNDS cycles, one round per cycle; the LFSR loads LFSR_INIT on entry.
REQ-024 Each round SHALL, in order:
 - XOR the LFSR value into state[LFSR_W-1:0];
 - XOR the bit-reversed LFSR value into state[B-1 -: LFSR_W];
 - apply the S-box to every nibble (E,D,B,0,2,1,4,F,7,A,8,5,9,C,3,6 for inputs 0..F);
 - apply the pLayer: bit j moves to (j*B/4) mod (B-1) for j<B-1, and bit B-1 is fixed.
REQ-025 LFSR step after each round: state = {state[LFSR_W-2:0], ^(state & LFSR_TAPS)}.
REQ-026 PERM exit:
 - to IDLE if the message is not finished;
 - to PAD if a pad block is pending;
 - otherwise to SQUEEZE.
REQ-027 SQUEEZE SHALL last 1 cycle and shift state[RATE-1:0] into hash from the MSB end.
REQ-028 SQUEEZE exit: DONE after N/RATE captures, otherwise PERM.
REQ-029 hash_valid SHALL rise on entry to DONE and stay high until the next transfer or rst.
REQ-030 msg_valid SHALL be ignored while msg_ready=0, and msg_data SHALL not be sampled then.
REQ-031 hash SHALL hold its value in IDLE, PERM, PAD and SQUEEZE, except for the shifts defined in REQ-027.

Reset
REQ-032 rst=1 SHALL, on the next edge and from any state (including mid-permutation or mid-squeeze), drive:
 - FSM to IDLE;
 - sponge state to 0;
 - LFSR to LFSR_INIT;
 - hash to 0;
 - hash_valid to 0;
 - the pad-pending flag and squeeze count to 0.
REQ-033 During and after reset msg_ready SHALL be 1 (IDLE), and rst SHALL take priority over any concurrent transfer.

Verification
REQ-034 Defaults, one word, msg_last=1, L=4, transfer at cycle 0 -> msg_ready low on cycles 1..506, hash_valid high from cycle 507, hash matches the golden model.
REQ-035 Defaults, one word, L=8 -> PAD cycle at 46, hash_valid at cycle 553, hash matches the golden model (pad block 0x80 absorbed).
REQ-036 Three-word message with msg_valid gaps and msg_valid asserted during PERM -> words taken only in IDLE, digest equals the no-gap digest.
REQ-037 rst pulsed at cycle 20 of a permutation, then the same message resent -> digest identical to a clean run, and hash/hash_valid read 0 after the reset.
REQ-038 Back-to-back messages, second word presented in DONE -> hash_valid drops in the transfer cycle, the second digest is independent of the first.
REQ-039 Parameter set N=CAP=128, RATE=8, ROUNDS=70, LFSR_W=7 -> digest matches the golden model.

Source files
------------

// File: rtl/spongent_sponge_if.sv
// Message/digest bus of the SPONGENT sponge: word stream in, digest out.
interface spongent_sponge_if #(
  parameter int N    = 88,
  parameter int RATE = 8
);
  localparam int LW = $clog2(RATE) + 1;

  logic [RATE-1:0] msg_data;
  logic            msg_valid;
  logic            msg_last;
  logic [LW-1:0]   msg_last_len;
  logic            msg_ready;
  logic [N-1:0]    hash;
  logic            hash_valid;

  modport master (
    output msg_data, msg_valid, msg_last, msg_last_len,
    input  msg_ready, hash, hash_valid
  );

  modport slave (
    input  msg_data, msg_valid, msg_last, msg_last_len,
    output msg_ready, hash, hash_valid
  );
endinterface

// File: rtl/spongent_sponge.sv
// SPONGENT sponge: absorbs RATE-bit words, one permutation round per cycle,
// then squeezes an N-bit digest that is held until the next message starts.
module spongent_sponge #(
  parameter int N      = 88,
  parameter int CAP    = 80,
  parameter int RATE   = 8,
  parameter int ROUNDS = 45,
  parameter int LFSR_W = 6,
  parameter logic [LFSR_W-1:0] LFSR_INIT = 6'h05,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 6'h30
) (
  input logic              clk,
  input logic              rst,
  spongent_sponge_if.slave bus
);
  localparam int B    = CAP + RATE;
  localparam int LW   = $clog2(RATE) + 1;
  localparam int NBLK = N / RATE;
  localparam int CW   = $clog2(NBLK + 1);
  localparam int RCW  = $clog2(ROUNDS + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PERM    = 3'd1;
  localparam logic [2:0] PAD     = 3'd2;
  localparam logic [2:0] SQUEEZE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        fsm_r, fsm_nxt_s;
  logic [B-1:0]      state_r;
  logic [LFSR_W-1:0] lfsr_r, lfsr_step_s;
  logic [N-1:0]      hash_r;
  logic              hash_valid_r, ready_r, pad_pend_r, msg_done_r;
  logic [CW-1:0]     sq_cnt_r;
  logic [RCW-1:0]    rnd_r;
  logic              xfer_s, last_round_s, full_last_s;
  logic [RATE-1:0]   word_s;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hE;  4'h1: sbox = 4'hD;  4'h2: sbox = 4'hB;  4'h3: sbox = 4'h0;
      4'h4: sbox = 4'h2;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h4;  4'h7: sbox = 4'hF;
      4'h8: sbox = 4'h7;  4'h9: sbox = 4'hA;  4'hA: sbox = 4'h8;  4'hB: sbox = 4'h5;
      4'hC: sbox = 4'h9;  4'hD: sbox = 4'hC;  4'hE: sbox = 4'h3;  4'hF: sbox = 4'h6;
      default: sbox = 4'h0;
    endcase
  endfunction

  // A short final word keeps its top L bits, gets a marker bit, zeros below it.
  function automatic logic [RATE-1:0] pad_word(input logic [RATE-1:0] d,
                                               input logic last,
                                               input logic [LW-1:0] len);
    logic [RATE-1:0] w;
    w = d;
    if (last && (int'(len) < RATE)) begin
      for (int i = 0; i < RATE; i++) begin
        if (i == RATE - 1 - int'(len)) w[i] = 1'b1;
        else if (i < RATE - 1 - int'(len)) w[i] = 1'b0;
        else w[i] = d[i];
      end
    end else begin
      w = d;
    end
    return w;
  endfunction

  function automatic logic [B-1:0] round_f(input logic [B-1:0] s,
                                           input logic [LFSR_W-1:0] l);
    logic [B-1:0] t, p;
    t = s;
    t[LFSR_W-1:0] = t[LFSR_W-1:0] ^ l;
    for (int i = 0; i < LFSR_W; i++) t[B-1-i] = t[B-1-i] ^ l[i];
    for (int k = 0; k < B / 4; k++) t[4*k +: 4] = sbox(t[4*k +: 4]);
    p = {B{1'b0}};
    for (int j = 0; j < B - 1; j++) p[(j * (B / 4)) % (B - 1)] = t[j];
    p[B-1] = t[B-1];
    return p;
  endfunction

  // Handshake, round bookkeeping and padded input word.
  always_comb begin
    xfer_s       = bus.msg_valid & ready_r;
    last_round_s = (rnd_r == RCW'(ROUNDS - 1));
    word_s       = pad_word(bus.msg_data, bus.msg_last, bus.msg_last_len);
    full_last_s  = bus.msg_last & (int'(bus.msg_last_len) >= RATE);
    lfsr_step_s  = {lfsr_r[LFSR_W-2:0], ^(lfsr_r & LFSR_TAPS)};
  end

  // Next-state decode of the sponge controller.
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      IDLE, DONE: begin
        if (xfer_s) fsm_nxt_s = PERM;
        else        fsm_nxt_s = fsm_r;
      end
      PERM: begin
        if (!last_round_s)   fsm_nxt_s = PERM;
        else if (!msg_done_r) fsm_nxt_s = IDLE;
        else if (pad_pend_r)  fsm_nxt_s = PAD;
        else                  fsm_nxt_s = SQUEEZE;
      end
      PAD:     fsm_nxt_s = PERM;
      SQUEEZE: begin
        if (sq_cnt_r == CW'(NBLK - 1)) fsm_nxt_s = DONE;
        else                           fsm_nxt_s = PERM;
      end
      default: fsm_nxt_s = IDLE;
    endcase
  end

  // Datapath and control registers; rst wins over any concurrent transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r        <= IDLE;
      ready_r      <= 1'b1;
      state_r      <= {B{1'b0}};
      lfsr_r       <= LFSR_INIT;
      hash_r       <= {N{1'b0}};
      hash_valid_r <= 1'b0;
      pad_pend_r   <= 1'b0;
      msg_done_r   <= 1'b0;
      sq_cnt_r     <= {CW{1'b0}};
      rnd_r        <= {RCW{1'b0}};
    end else begin
      fsm_r   <= fsm_nxt_s;
      ready_r <= (fsm_nxt_s == IDLE) || (fsm_nxt_s == DONE);
      // The LFSR idles at its seed so every permutation starts from LFSR_INIT.
      lfsr_r  <= ((fsm_r == PERM) && !last_round_s) ? lfsr_step_s : LFSR_INIT;
      rnd_r   <= ((fsm_r == PERM) && !last_round_s) ? rnd_r + RCW'(1) : {RCW{1'b0}};
      case (fsm_r)
        IDLE, DONE: begin
          if (xfer_s) begin
            if (fsm_r == DONE) begin
              state_r      <= {{CAP{1'b0}}, word_s};
              hash_r       <= {N{1'b0}};
              hash_valid_r <= 1'b0;
            end else begin
              state_r <= {state_r[B-1:RATE], state_r[RATE-1:0] ^ word_s};
            end
            msg_done_r <= bus.msg_last;
            pad_pend_r <= full_last_s;
            sq_cnt_r   <= {CW{1'b0}};
          end
        end
        PERM: state_r <= round_f(state_r, lfsr_r);
        PAD: begin
          state_r[RATE-1] <= ~state_r[RATE-1];
          pad_pend_r      <= 1'b0;
        end
        SQUEEZE: begin
          hash_r   <= {hash_r[N-RATE-1:0], state_r[RATE-1:0]};
          sq_cnt_r <= sq_cnt_r + CW'(1);
          if (fsm_nxt_s == DONE) hash_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.msg_ready  = ready_r;
  assign bus.hash       = hash_r;
  assign bus.hash_valid = hash_valid_r;
endmodule

// File: tb/tb_spongent_sponge.sv
// Bench for spongent_sponge: table vectors, corner sequences and random
// messages checked against a bit-string sponge reference model.
module tb_spongent_sponge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spongent_sponge_if #(.N(88),  .RATE(8)) ia ();
  spongent_sponge_if #(.N(128), .RATE(8)) ib ();

  spongent_sponge dut_a (.clk(clk), .rst(rst), .bus(ia));
  spongent_sponge #(.N(128), .CAP(128), .RATE(8), .ROUNDS(70), .LFSR_W(7),
                    .LFSR_INIT(7'h7A), .LFSR_TAPS(7'h60))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  localparam int SB [16] = '{14, 13, 11, 0, 2, 1, 4, 15, 7, 10, 8, 5, 9, 12, 3, 6};

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    int         len;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] ref_perm(input logic [255:0] s_in, input int b,
      input int rounds, input int lw, input int init, input int taps);
    logic [255:0] s, t;
    int l, fb, nib;
    s = s_in;
    l = init;
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < lw; i++) begin
        s[i]       = s[i] ^ l[i];
        s[b-1-i]   = s[b-1-i] ^ l[i];
      end
      for (int k = 0; k < b / 4; k++) begin
        nib = int'(s[4*k +: 4]);
        s[4*k +: 4] = 4'(SB[nib]);
      end
      t = 256'd0;
      for (int j = 0; j < b - 1; j++) t[(j * (b / 4)) % (b - 1)] = s[j];
      t[b-1] = s[b-1];
      s = t;
      fb = $countones(l & taps) % 2;
      l = ((l << 1) | fb) & ((1 << lw) - 1);
    end
    return s;
  endfunction

  // Message as a bit string: valid bits, a single 1, zero fill to whole blocks.
  function automatic logic [255:0] ref_digest(input logic [7:0] w [4], input int nw,
      input int ll, input int n, input int cap, input int rounds, input int lw,
      input int init, input int taps);
    bit q[$];
    logic [255:0] s, d;
    int bits;
    for (int i = 0; i < nw; i++) begin
      bits = (i == nw - 1) ? ll : 8;
      for (int j = 0; j < bits; j++) q.push_back(w[i][7-j]);
    end
    q.push_back(1'b1);
    while (q.size() % 8 != 0) q.push_back(1'b0);
    s = 256'd0;
    for (int blk = 0; blk < q.size() / 8; blk++) begin
      for (int j = 0; j < 8; j++) s[7-j] = s[7-j] ^ q[blk*8+j];
      s = ref_perm(s, cap + 8, rounds, lw, init, taps);
    end
    d = 256'd0;
    for (int k = 0; k < n / 8; k++) begin
      for (int j = 0; j < 8; j++) d[n-1-k*8-j] = s[7-j];
      if (k < n / 8 - 1) s = ref_perm(s, cap + 8, rounds, lw, init, taps);
    end
    return d;
  endfunction

  // Sends a message to dut_a; lat counts cycles from the last transfer to hash_valid.
  task automatic send_a(input logic [7:0] w [4], input int nw, input int ll,
      input int gap_max, input bit junk, output int lat, output int ready_hi,
      output logic hv1, output logic [87:0] h1);
    int n;
    hv1 = 1'b0;
    h1  = 88'd0;
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        ia.msg_valid = 1'b0;
        @(posedge clk); #1;
      end
      ia.msg_data     = w[i];
      ia.msg_valid    = 1'b1;
      ia.msg_last     = (i == nw - 1);
      ia.msg_last_len = (i == nw - 1) ? 4'(ll) : 4'($urandom_range(8, 1));
      n = 0;
      while (!ia.msg_ready && n < 3000) begin @(posedge clk); #1; n++; end
      if (!ia.msg_ready) check("ready_timeout", 256'd0, 256'd1);
      @(posedge clk); #1;
      if (i == 0) begin hv1 = ia.hash_valid; h1 = ia.hash; end
      ia.msg_valid = 1'b0;
      ia.msg_data  = 8'($urandom);
      if (i < nw - 1) begin
        n = 0;
        while (!ia.msg_ready && n < 3000) begin
          ia.msg_valid = junk;
          ia.msg_data  = 8'($urandom);
          ia.msg_last  = 1'($urandom);
          @(posedge clk); #1;
          n++;
        end
      end
    end
    ia.msg_valid = 1'b0;
    lat = 1;
    ready_hi = 0;
    while (!ia.hash_valid && lat < 3000) begin
      if (ia.msg_ready) ready_hi++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send_b(input logic [7:0] w [4], input int nw, input int ll, output int lat);
    int n;
    for (int i = 0; i < nw; i++) begin
      ib.msg_data     = w[i];
      ib.msg_valid    = 1'b1;
      ib.msg_last     = (i == nw - 1);
      ib.msg_last_len = 4'(ll);
      n = 0;
      while (!ib.msg_ready && n < 3000) begin @(posedge clk); #1; n++; end
      if (!ib.msg_ready) check("b_ready_timeout", 256'd0, 256'd1);
      @(posedge clk); #1;
      ib.msg_valid = 1'b0;
    end
    lat = 1;
    while (!ib.hash_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    vec_t        tbl [5];
    logic [7:0]  msg [4];
    int          lat, rh, nw, ll;
    logic        hv1;
    logic [87:0] h1, h_gap;

    tbl[0] = '{8'hA5, 4, 507};
    tbl[1] = '{8'hFF, 8, 553};
    tbl[2] = '{8'h00, 1, 507};
    tbl[3] = '{8'h3C, 7, 507};
    tbl[4] = '{8'h81, 8, 553};

    rst = 1'b1;
    ia.msg_data = 8'd0; ia.msg_valid = 1'b0; ia.msg_last = 1'b0; ia.msg_last_len = 4'd0;
    ib.msg_data = 8'd0; ib.msg_valid = 1'b0; ib.msg_last = 1'b0; ib.msg_last_len = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 256'(ia.msg_ready), 256'd1);
    check("reset_hash_valid", 256'(ia.hash_valid), 256'd0);
    check("reset_hash", 256'(ia.hash), 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int e = 0; e < 5; e++) begin
      msg[0] = tbl[e].data;
      send_a(msg, 1, tbl[e].len, 0, 1'b0, lat, rh, hv1, h1);
      check($sformatf("tbl%0d_latency", e), 256'(lat), 256'(tbl[e].exp_lat));
      check($sformatf("tbl%0d_ready_low", e), 256'(rh), 256'd0);
      check($sformatf("tbl%0d_digest", e), 256'(ia.hash),
            ref_digest(msg, 1, tbl[e].len, 88, 80, 45, 6, 'h05, 'h30));
      check($sformatf("tbl%0d_hv_drop", e), 256'(hv1), 256'd0);
      check($sformatf("tbl%0d_hash_clear", e), 256'(h1), 256'd0);
    end

    // Three words with idle gaps and junk offered while the permutation runs.
    msg[0] = 8'h3C; msg[1] = 8'hC3; msg[2] = 8'h5A;
    send_a(msg, 3, 5, 3, 1'b1, lat, rh, hv1, h1);
    h_gap = ia.hash;
    check("gap_digest", 256'(h_gap), ref_digest(msg, 3, 5, 88, 80, 45, 6, 'h05, 'h30));
    check("gap_latency", 256'(lat), 256'd507);
    send_a(msg, 3, 5, 0, 1'b0, lat, rh, hv1, h1);
    check("gap_vs_nogap", 256'(ia.hash), 256'(h_gap));

    // Reset deep inside a squeeze-phase permutation, with a transfer offered under rst.
    msg[0] = 8'h96;
    ia.msg_data = msg[0]; ia.msg_valid = 1'b1; ia.msg_last = 1'b1; ia.msg_last_len = 4'd6;
    @(posedge clk); #1;
    ia.msg_valid = 1'b0;
    repeat (157) begin @(posedge clk); #1; end
    rst = 1'b1;
    ia.msg_valid = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 256'(ia.msg_ready), 256'd1);
    check("midrst_hash_valid", 256'(ia.hash_valid), 256'd0);
    check("midrst_hash", 256'(ia.hash), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ia.msg_valid = 1'b0;
    check("rst_priority_ready", 256'(ia.msg_ready), 256'd1);
    send_a(msg, 1, 6, 0, 1'b0, lat, rh, hv1, h1);
    check("postrst_digest", 256'(ia.hash), ref_digest(msg, 1, 6, 88, 80, 45, 6, 'h05, 'h30));
    check("postrst_latency", 256'(lat), 256'd507);

    for (int m = 0; m < 6; m++) begin
      nw = $urandom_range(3, 1);
      ll = $urandom_range(8, 1);
      for (int i = 0; i < 4; i++) msg[i] = 8'($urandom);
      send_a(msg, nw, ll, 2, 1'b1, lat, rh, hv1, h1);
      check($sformatf("rand%0d_digest", m), 256'(ia.hash),
            ref_digest(msg, nw, ll, 88, 80, 45, 6, 'h05, 'h30));
      check($sformatf("rand%0d_latency", m), 256'(lat), (ll == 8) ? 256'd553 : 256'd507);
    end

    msg[0] = 8'h00;
    send_b(msg, 1, 8, lat);
    check("b0_digest", 256'(ib.hash), ref_digest(msg, 1, 8, 128, 128, 70, 7, 'h7A, 'h60));
    check("b0_latency", 256'(lat), 256'd1208);
    msg[0] = 8'($urandom); msg[1] = 8'($urandom);
    send_b(msg, 2, 3, lat);
    check("b1_digest", 256'(ib.hash), ref_digest(msg, 2, 3, 128, 128, 70, 7, 'h7A, 'h60));
    check("b1_latency", 256'(lat), 256'd1137);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
